// File: rtl/rv_reg_file_sb_if.sv
// Decode-stage register file bus: two read ports with busy flags, one
// writeback port, one issue port and the initialisation status.
interface rv_reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rd_addr1_i;
  logic [AW-1:0]   rd_addr2_i;
  logic [XLEN-1:0] rd_data1_o;
  logic [XLEN-1:0] rd_data2_o;
  logic            rd_busy1_o;
  logic            rd_busy2_o;
  logic            wr_en_i;
  logic [AW-1:0]   wr_addr_i;
  logic [XLEN-1:0] wr_data_i;
  logic            issue_en_i;
  logic [AW-1:0]   issue_addr_i;
  logic            init_done_o;

  modport slave (
    input  rd_addr1_i, rd_addr2_i, wr_en_i, wr_addr_i, wr_data_i,
           issue_en_i, issue_addr_i,
    output rd_data1_o, rd_data2_o, rd_busy1_o, rd_busy2_o, init_done_o
  );

  modport master (
    output rd_addr1_i, rd_addr2_i, wr_en_i, wr_addr_i, wr_data_i,
           issue_en_i, issue_addr_i,
    input  rd_data1_o, rd_data2_o, rd_busy1_o, rd_busy2_o, init_done_o
  );
endinterface

// File: rtl/rv_reg_file_sb.sv
// RISC-V integer register file with writeback bypass, pending-write
// scoreboard and a post-reset sweep that clears every register.
module rv_reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  rv_reg_file_sb_if.slave rf
);

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             init_done_q, init_done_d;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic             regs_we;
  logic [AW-1:0]    regs_waddr;
  logic [XLEN-1:0]  regs_wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    regs_we    = 1'b0;
    regs_waddr = rf.wr_addr_i;
    regs_wdata = rf.wr_data_i;
    case (state_q)
      INIT: begin
        regs_we    = 1'b1;
        regs_waddr = cnt_q;
        regs_wdata = '0;
        cnt_d      = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
      end
      RUN: begin
        if (rf.wr_en_i && (rf.wr_addr_i != '0)) begin
          regs_we                = 1'b1;
          pend_d[rf.wr_addr_i]   = 1'b0;
        end
        // Issue is applied after writeback so a same-address pair leaves
        // the register pending on the newer producer.
        if (rf.issue_en_i && (rf.issue_addr_i != '0)) pend_d[rf.issue_addr_i] = 1'b1;
      end
      default: state_d = INIT;
    endcase
    init_done_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      pend_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (regs_we) regs_q[regs_waddr] <= regs_wdata;
  end

  // Reads are zero-latency; a same-cycle writeback wins over the array and
  // clears the busy flag because the value is being delivered right now.
  always_comb begin
    rf.rd_data1_o = '0;
    rf.rd_busy1_o = 1'b0;
    rf.rd_data2_o = '0;
    rf.rd_busy2_o = 1'b0;
    if (state_q == RUN) begin
      if (rf.rd_addr1_i != '0) begin
        if (rf.wr_en_i && (rf.wr_addr_i == rf.rd_addr1_i)) begin
          rf.rd_data1_o = rf.wr_data_i;
        end else begin
          rf.rd_data1_o = regs_q[rf.rd_addr1_i];
          rf.rd_busy1_o = pend_q[rf.rd_addr1_i];
        end
      end
      if (rf.rd_addr2_i != '0) begin
        if (rf.wr_en_i && (rf.wr_addr_i == rf.rd_addr2_i)) begin
          rf.rd_data2_o = rf.wr_data_i;
        end else begin
          rf.rd_data2_o = regs_q[rf.rd_addr2_i];
          rf.rd_busy2_o = pend_q[rf.rd_addr2_i];
        end
      end
    end
  end

  assign rf.init_done_o = init_done_q;

endmodule
